// File: rtl/arith_unit_pipe_pkg.sv
// arith_pkg: op encodings and status flag bundle shared by the arith_unit_pipe slice
package arith_pkg;
  typedef enum logic [1:0] {
    OP_INC = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_DEC = 2'b11
  } op_e;
  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;
endpackage

// File: rtl/arith_unit_pipe_if.sv
// arith_unit_pipe_if: request/result handshake bundle between operand source and result consumer
interface arith_unit_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic             cin;
  logic             acc_src;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic [WIDTH-1:0] acc;
  modport slave (
    input  in_valid, sel, cin, acc_src, x, y, out_ready,
    output in_ready, out_valid, f, cout, zero, neg, ovf, acc
  );
  modport master (
    output in_valid, sel, cin, acc_src, x, y, out_ready,
    input  in_ready, out_valid, f, cout, zero, neg, ovf, acc
  );
endinterface

// File: rtl/arith_unit_pipe_addsub_core.sv
// addsub_core: combinational ripple-carry a+b+c with carry-out and signed overflow
module addsub_core #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH:0] cy;
  assign cy[0] = c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end
  assign cout = cy[WIDTH];
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: two-stage inc/add/sub/dec unit with accumulator and valid/ready handshake
// Define ARITH_SAT_EN to clamp overflowing results (and acc) instead of wrapping.
module arith_unit_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  arith_unit_pipe_if.slave bus
);
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_sel_q, s1_sel_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_acc_src_q, s1_acc_src_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             s2_adv, in_ready, accept, fire;
  logic [WIDTH-1:0] a, b, sum, res;
  logic             c, co, ov;
  flags_t           res_flags;
  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (a),
    .b    (b),
    .c    (c),
    .sum  (sum),
    .cout (co),
    .ovf  (ov)
  );
  always_comb begin
    s2_adv    = !out_valid_q || bus.out_ready;
    in_ready  = rst_n && (!s1_valid_q || s2_adv);
    accept    = bus.in_valid && in_ready;
    fire      = s1_valid_q && s2_adv;
    // acc is read here, at compute time, so chained acc_src ops need no bubble
    a         = s1_acc_src_q ? acc_q : s1_x_q;
    b         = s1_sel_q == OP_INC ? '0 :
                s1_sel_q == OP_ADD ? s1_y_q :
                s1_sel_q == OP_SUB ? ~s1_y_q : '1;
    c         = s1_sel_q == OP_SUB ? ~s1_cin_q : s1_cin_q;
`ifdef ARITH_SAT_EN
    res       = !ov ? sum : a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    res       = sum;
`endif
    res_flags = '{zero: res == '0, neg: res[WIDTH-1], ovf: ov};
    s1_valid_d   = accept || (s1_valid_q && !s2_adv);
    s1_sel_d     = accept ? op_e'(bus.sel) : s1_sel_q;
    s1_cin_d     = accept ? bus.cin : s1_cin_q;
    s1_acc_src_d = accept ? bus.acc_src : s1_acc_src_q;
    s1_x_d       = accept ? bus.x : s1_x_q;
    s1_y_d       = accept ? bus.y : s1_y_q;
    out_valid_d  = s2_adv ? s1_valid_q : out_valid_q;
    f_d          = fire ? res : f_q;
    cout_d       = fire ? co : cout_q;
    flags_d      = fire ? res_flags : flags_q;
    acc_d        = fire ? res : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sel_q     <= OP_INC;
      s1_cin_q     <= 1'b0;
      s1_acc_src_q <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      out_valid_q  <= 1'b0;
      f_q          <= '0;
      cout_q       <= 1'b0;
      flags_q      <= '0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sel_q     <= s1_sel_d;
      s1_cin_q     <= s1_cin_d;
      s1_acc_src_q <= s1_acc_src_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      out_valid_q  <= out_valid_d;
      f_q          <= f_d;
      cout_q       <= cout_d;
      flags_q      <= flags_d;
      acc_q        <= acc_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.ovf       = flags_q.ovf;
  assign bus.acc       = acc_q;
endmodule

// File: tb/tb_arith_unit_pipe.sv
// tb_arith_unit_pipe: directed plus randomized checks of arith_unit_pipe against a transaction-level model
module tb_arith_unit_pipe;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  int obs = 0;
  int n_acc;
  logic ok;
  arith_unit_pipe_if #(.WIDTH(W)) bus ();
  arith_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;

  // model: one optional pending op (first stage) and one result slot
  logic       m_s1v, m_cin, m_src, m_ov, m_co, m_z, m_n, m_o;
  logic [1:0] m_sel;
  logic [7:0] m_x, m_y, m_f, m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [1:0] s, input logic ci, input logic [7:0] a,
                                   input logic [7:0] y, output logic [7:0] f, output logic co,
                                   output logic o);
    int bv, c, tot, sa, sb, st;
    bv  = s == 2'd0 ? 0 : s == 2'd1 ? int'(y) : s == 2'd2 ? 255 - int'(y) : 255;
    c   = s == 2'd2 ? int'(!ci) : int'(ci);
    tot = int'(a) + bv + c;
    co  = tot > 255;
    f   = 8'(tot);
    sa  = a >= 8'd128 ? int'(a) - 256 : int'(a);
    sb  = bv >= 128 ? bv - 256 : bv;
    st  = sa + sb + c;
    o   = st > 127 || st < -128;
`ifdef ARITH_SAT_EN
    if (o) f = sa < 0 ? 8'd128 : 8'd127;
`endif
  endfunction

  task automatic step(input logic iv, input logic [1:0] s, input logic ci, input logic src,
                      input logic [7:0] x, input logic [7:0] y, input logic ordy,
                      input logic rn, output logic acc_o);
    logic adv;
    logic [7:0] a, rf;
    logic rc, ro;
    @(negedge clk);
    chk("in_ready", bus.in_ready, rst_n && (!m_s1v || !m_ov || bus.out_ready));
    chk("out_valid", bus.out_valid, m_ov);
    chk("acc", bus.acc, m_acc);
    chk("f", bus.f, m_f);
    chk("cout", bus.cout, m_co);
    chk("zero", bus.zero, m_z);
    chk("neg", bus.neg, m_n);
    chk("ovf", bus.ovf, m_o);
    rst_n = rn;
    bus.in_valid = iv;
    bus.sel = s;
    bus.cin = ci;
    bus.acc_src = src;
    bus.x = x;
    bus.y = y;
    bus.out_ready = ordy;
    acc_o = 1'b0;
    if (bus.out_valid && ordy && rn) obs++;
    if (!rn) begin
      {m_s1v, m_ov, m_co, m_z, m_n, m_o} = '0;
      m_f = '0;
      m_acc = '0;
    end else begin
      adv = !m_ov || ordy;
      acc_o = iv && (!m_s1v || adv);
      if (adv) begin
        if (m_s1v) begin
          a = m_src ? m_acc : m_x;
          model_op(m_sel, m_cin, a, m_y, rf, rc, ro);
          m_f = rf; m_co = rc; m_o = ro; m_acc = rf;
          m_z = rf == 8'd0; m_n = rf[7];
        end
        m_ov = m_s1v;
      end
      if (acc_o) begin
        m_s1v = 1'b1; m_sel = s; m_cin = ci; m_src = src; m_x = x; m_y = y;
      end else if (adv) m_s1v = 1'b0;
    end
  endtask

  logic [7:0] t1 [8];
  logic       p_has, p_cin, p_src;
  logic [1:0] p_sel;
  logic [7:0] p_x, p_y;
  int         r, ob0;

  initial begin
    t1 = '{8'd36, 8'd37, 8'd60, 8'd61, 8'd12, 8'd11, 8'd35, 8'd36};
    {m_s1v, m_cin, m_src, m_ov, m_co, m_z, m_n, m_o} = '0;
    m_sel = '0; m_x = '0; m_y = '0; m_f = '0; m_acc = '0;
    bus.in_valid = 1'b0; bus.sel = '0; bus.cin = 1'b0; bus.acc_src = 1'b0;
    bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 1, 0, ok);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_f", bus.f, 0);
    chk("rst_zero", bus.zero, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    // sel/cin sweep, one op per cycle
    for (int k = 0; k < 10; k++) begin
      step(k < 8, 2'(k / 2), 1'(k % 2), 0, 36, 24, 1, 1, ok);
      #1;
      if (k >= 2) chk("sweep_f", bus.f, t1[k-2]);
      if (k == 6) chk("sub_cout", bus.cout, 1);
    end
    step(1, 1, 0, 0, 100, 100, 1, 1, ok);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    #1;
`ifdef ARITH_SAT_EN
    chk("add_ovf_f", bus.f, 127);
    chk("add_ovf_neg", bus.neg, 0);
`else
    chk("add_ovf_f", bus.f, 200);
    chk("add_ovf_neg", bus.neg, 1);
`endif
    chk("add_ovf_ovf", bus.ovf, 1);
    chk("add_ovf_cout", bus.cout, 0);
    step(1, 2, 0, 0, 5, 5, 1, 1, ok);
    step(1, 3, 0, 0, 0, 9, 1, 1, ok);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    #1;
    chk("sub_eq_f", bus.f, 0);
    chk("sub_eq_zero", bus.zero, 1);
    chk("sub_eq_cout", bus.cout, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    #1;
    chk("dec0_f", bus.f, 255);
    chk("dec0_neg", bus.neg, 1);
    chk("dec0_cout", bus.cout, 0);
    // accumulator chain
    for (int k = 0; k < 6; k++) begin
      step(k < 4, 1, 0, k > 0, 10, k > 0 ? 8'd5 : 8'd0, 1, 1, ok);
      #1;
      if (k >= 2) begin
        chk("chain_valid", bus.out_valid, 1);
        chk("chain_f", bus.f, 10 + 5 * (k - 2));
      end
    end
    // backpressure: three requests offered while the consumer stalls
    n_acc = 0; r = 0; ob0 = obs;
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 8'(r + 1), 8'(r), 0, 1, ok);
      if (ok) begin n_acc++; r++; end
    end
    #1;
    chk("bp_accepted", n_acc, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_f_held", bus.f, 1);
    for (int k = 0; k < 6; k++) begin
      step(r < 3, 1, 0, 0, 8'(r + 1), 8'(r), 1, 1, ok);
      if (ok) r++;
    end
    chk("bp_drained", obs - ob0, 3);
    // reset with both stages full
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 8'(50 + k), 0, 0, 1, ok);
    step(0, 0, 0, 0, 0, 0, 0, 0, ok);
    #1;
    chk("rst_mid_in_ready", bus.in_ready, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_acc", bus.acc, 0);
    chk("rst_mid_f", bus.f, 0);
    chk("rst_mid_in_ready1", bus.in_ready, 1);
    // randomized traffic with held requests, stalls and occasional reset
    p_has = 1'b0; p_sel = '0; p_cin = 1'b0; p_src = 1'b0; p_x = '0; p_y = '0;
    for (int k = 0; k < 500; k++) begin
      if (!p_has && $urandom_range(0, 2) != 0) begin
        p_has = 1'b1;
        p_sel = 2'($urandom);
        p_cin = 1'($urandom);
        p_src = 1'($urandom);
        p_x = 8'($urandom);
        p_y = 8'($urandom);
      end
      step(p_has, p_sel, p_cin, p_src, p_x, p_y, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) != 0, ok);
      if (ok) p_has = 1'b0;
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 1, 1, ok);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
